// File: rtl/if_stage_pkg.sv
// Shared widths, bus layouts and reset PC for the fetch stage.
// Bus widths live here so every stage sees one definition.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC        = 32'hBFC0_0000;
    localparam int          BR_BUS_WD       = 34;
    localparam int          FS_TO_DS_BUS_WD = 64;

    typedef struct packed {
        logic        stall;
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage boundary: fs->ds handshake, branch bus and inst SRAM port.
// master is the fetch stage; slave is decode plus the SRAM.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_en;
    logic [3:0]                 inst_sram_wen;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_rdata;

    modport master (
        input  ds_allowin,
        input  br_bus,
        input  inst_sram_rdata,
        output fs_to_ds_valid,
        output fs_to_ds_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        output ds_allowin,
        output br_bus,
        output inst_sram_rdata,
        input  fs_to_ds_valid,
        input  fs_to_ds_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata
    );

endinterface

// File: rtl/if_stage.sv
// Fetch stage: pre-IF PC select driving the inst SRAM, IF register,
// plus buffers for the instruction and a pending branch target.
module if_stage
    import if_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    if_stage_if.master bus
);

    br_bus_t     br;
    fs_to_ds_t   fs_out;
    logic        to_fs_valid;
    logic        fs_valid;
    logic        fs_allowin;
    logic        fire;
    logic        br_now;
    logic [31:0] fs_pc;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;
    logic        inst_buf_valid;
    logic [31:0] inst_buf;
    logic        br_buf_valid;
    logic [31:0] br_buf_target;

    assign br         = br_bus_t'(bus.br_bus);
    assign br_now     = br.taken & ~br.stall;
    assign fs_allowin = ~fs_valid | bus.ds_allowin;
    assign fire       = to_fs_valid & fs_allowin & ~br.stall;

    always_comb begin
        nextpc = seq_pc(fs_pc);
        if (br_buf_valid)
            nextpc = br_buf_target;
        else if (br_now)
            nextpc = br.target;
    end

    assign bus.inst_sram_en    = fire;
    assign bus.inst_sram_addr  = nextpc;
    assign bus.inst_sram_wen   = 4'h0;
    assign bus.inst_sram_wdata = 32'h0;

    assign fs_inst = inst_buf_valid ? inst_buf : bus.inst_sram_rdata;
    assign fs_out  = '{inst: fs_inst, pc: fs_pc};

    assign bus.fs_to_ds_valid = fs_valid;
    assign bus.fs_to_ds_bus   = fs_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            to_fs_valid <= 1'b0;
        else
            to_fs_valid <= 1'b1;
    end

    // A drained IF clears valid so decode never sees a duplicate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - 32'd4;
        end else if (fire) begin
            fs_valid <= 1'b1;
            fs_pc    <= nextpc;
        end else if (fs_allowin) begin
            fs_valid <= 1'b0;
        end
    end

    // SRAM data is only good for one cycle; keep it while decode stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_buf_valid <= 1'b0;
            inst_buf       <= 32'h0;
        end else if (fire) begin
            inst_buf_valid <= 1'b0;
        end else if (fs_valid & ~inst_buf_valid & ~bus.ds_allowin) begin
            inst_buf_valid <= 1'b1;
            inst_buf       <= bus.inst_sram_rdata;
        end
    end

    // Target resolved before IF can issue is held for the next fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_buf_valid  <= 1'b0;
            br_buf_target <= 32'h0;
        end else if (fire) begin
            br_buf_valid  <= 1'b0;
        end else if (br_now & ~br_buf_valid) begin
            br_buf_valid  <= 1'b1;
            br_buf_target <= br.target;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomised bench for if_stage: decode-side model with delay-slot
// branches, SRAM model, and an in-order scoreboard of fetched PCs.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;

    if_stage_if bus ();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Synchronous SRAM; junk when not enabled so a missing buffer shows.
    always @(posedge clk) begin
        if (bus.inst_sram_en)
            bus.inst_sram_rdata <= mem(bus.inst_sram_addr);
        else
            bus.inst_sram_rdata <= $urandom;
    end

    int          nvec = 0;
    int          nerr = 0;
    int          n_hs = 0;
    logic [31:0] sb[$];
    bit          hs;
    logic [31:0] hs_pc;
    bit          redir;
    logic [31:0] redir_t;
    bit          br_id;
    logic [31:0] br_t;
    int          stall_n;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic [31:0] e;
        forever begin
            @(negedge clk);
            hs = 1'b0;
            if (!reset && bus.fs_to_ds_valid && bus.ds_allowin) begin
                n_hs++;
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL sb_empty: got pc %h expected none",
                             bus.fs_to_ds_bus[31:0]);
                end else begin
                    e = sb.pop_front();
                    chk("deliver", bus.fs_to_ds_bus, {mem(e), e});
                    hs    = 1'b1;
                    hs_pc = e;
                end
            end
        end
    endtask

    // mode 0: go, 1: random decode, 2: decode stalled
    task automatic drive(input int mode);
        @(posedge clk);
        #1;
        if (hs) begin
            bit          slot;
            logic [31:0] nx;
            slot  = redir;
            nx    = redir ? redir_t : hs_pc + 32'd4;
            redir = 1'b0;
            br_id = 1'b0;
            if (mode == 1 && !slot && $urandom_range(0, 3) == 0) begin
                br_id   = 1'b1;
                br_t    = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 :
                          (32'h8000_0000 | ($urandom & 32'h0FFF_FFFC));
                stall_n = $urandom_range(0, 2);
                redir   = 1'b1;
                redir_t = br_t;
            end
            sb.push_back(nx);
        end
        if (br_id && stall_n > 0) begin
            bus.br_bus     = {1'b1, 1'b0, 32'h0};
            bus.ds_allowin = 1'b0;
            stall_n--;
        end else if (br_id) begin
            bus.br_bus     = {1'b0, 1'b1, br_t};
            bus.ds_allowin = (mode == 1) ? ($urandom_range(0, 2) != 0) :
                             (mode == 0);
        end else begin
            bus.br_bus     = '0;
            bus.ds_allowin = (mode == 1) ? ($urandom_range(0, 3) != 0) :
                             (mode == 0);
        end
    endtask

    task automatic restart();
        sb.delete();
        sb.push_back(RESET_PC);
        redir = 1'b0;
        br_id = 1'b0;
        stall_n = 0;
        bus.br_bus = '0;
        bus.ds_allowin = 1'b1;
    endtask

    task automatic release_and_start();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("en_first_cycle", {63'd0, bus.inst_sram_en}, 64'd0);
        drive(0);
        @(negedge clk);
        chk("addr0", {31'd0, bus.inst_sram_en, bus.inst_sram_addr},
            {31'd0, 1'b1, RESET_PC});
        drive(0);
        @(negedge clk);
        chk("addr1", {31'd0, bus.inst_sram_en, bus.inst_sram_addr},
            {31'd0, 1'b1, RESET_PC + 32'd4});
    endtask

    initial begin
        hs = 1'b0;
        hs_pc = '0;
        redir_t = '0;
        br_t = '0;
        bus.inst_sram_rdata = '0;
        restart();
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {63'd0, bus.fs_to_ds_valid}, 64'd0);
        chk("rst_en", {63'd0, bus.inst_sram_en}, 64'd0);
        chk("rst_pc", {32'd0, bus.fs_to_ds_bus[31:0]},
            {32'd0, RESET_PC - 32'd4});
        chk("tied", {28'd0, bus.inst_sram_wen, bus.inst_sram_wdata}, 64'd0);

        release_and_start();
        drive(0);
        repeat (3) begin
            drive(2);
            @(negedge clk);
            chk("hold_en", {63'd0, bus.inst_sram_en}, 64'd0);
            chk("hold_bus", {31'd0, bus.fs_to_ds_valid, bus.fs_to_ds_bus[31:0]},
                {31'd0, 1'b1, RESET_PC + 32'd8});
            chk("hold_inst", {32'd0, bus.fs_to_ds_bus[63:32]},
                {32'd0, mem(sb[0])});
        end
        drive(0);
        @(negedge clk);
        chk("resume", {31'd0, bus.inst_sram_en, bus.inst_sram_addr},
            {31'd0, 1'b1, RESET_PC + 32'd12});

        repeat (3000) drive(1);

        @(posedge clk);
        #1;
        bus.ds_allowin = 1'b0;
        bus.br_bus = {1'b0, 1'b1, 32'h8000_3000};
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, bus.fs_to_ds_valid}, 64'd0);
        chk("mid_rst_en", {63'd0, bus.inst_sram_en}, 64'd0);
        chk("mid_rst_pc", {32'd0, bus.fs_to_ds_bus[31:0]},
            {32'd0, RESET_PC - 32'd4});
        restart();
        release_and_start();

        repeat (3000) drive(1);
        repeat (4) drive(0);

        chk("progress", {63'd0, n_hs > 1000}, 64'd1);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
